in_byte_framer: RTL

Upstream input stage of the byte-processing pipeline. It accepts a raw 8-bit byte stream and strips framing. It delivers payload bytes through a small FIFO, with start/end-of-frame marks, to the downstream 8-bit `IN` consumer. It also validates frame length and checksum and keeps a count of good frames.

---
 rtl/in_byte_framer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/in_byte_framer.sv
// Input framer: strips HDR/LEN/CSUM framing from a raw byte stream, queues payload
// bytes with SOF/EOF tags in a small FIFO, and flags bad lengths and checksums.
module in_byte_framer #(
  parameter logic [7:0] HDR    = 8'hA5,
  parameter int         MAXLEN = 16,
  parameter int         DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] IN_DATA,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OUT_SOF,
  output logic       OUT_EOF,
  output logic       ERR_LEN,
  output logic       ERR_CSUM,
  output logic [7:0] FRAME_CNT
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic [7:0] MAXLEN_B = 8'(MAXLEN);

  typedef enum logic [1:0] {S_IDLE, S_LEN, S_PAYLOAD, S_CSUM} state_t;

  state_t      state_q, state_d;
  logic [7:0]  rem_q, rem_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        first_q, first_d;
  logic        err_len_q, err_len_d;
  logic        err_csum_q, err_csum_d;
  logic [9:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [9:0]  head;
  logic        accept, push, pop, empty, full, len_ok;

  assign len_ok = (IN_DATA != 8'd0) && (IN_DATA <= MAXLEN_B);
  assign accept = IN_VALID && IN_READY;
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        S_IDLE:    if (IN_DATA == HDR) state_d = S_LEN;
        S_LEN:     state_d = len_ok ? S_PAYLOAD : S_IDLE;
        S_PAYLOAD: if (rem_q == 8'd1) state_d = S_CSUM;
        S_CSUM:    state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Full is taken from registered pointers only, so OUT_READY never reaches IN_READY.
  always_comb begin
    IN_READY = !RST && !((state_q == S_PAYLOAD) && full);
    push     = accept && (state_q == S_PAYLOAD);
  end

  always_comb begin
    rem_d      = rem_q;
    sum_d      = sum_q;
    first_d    = first_q;
    cnt_d      = cnt_q;
    err_len_d  = 1'b0;
    err_csum_d = 1'b0;
    if (accept) begin
      unique case (state_q)
        S_LEN: begin
          if (len_ok) begin
            rem_d   = IN_DATA;
            sum_d   = 8'd0;
            first_d = 1'b1;
          end else begin
            err_len_d = 1'b1;
          end
        end
        S_PAYLOAD: begin
          rem_d   = rem_q - 8'd1;
          sum_d   = sum_q + IN_DATA;
          first_d = 1'b0;
        end
        S_CSUM: begin
          if (IN_DATA == sum_q) cnt_d = cnt_q + 8'd1;
          else                  err_csum_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rem_q      <= 8'd0;
      sum_q      <= 8'd0;
      cnt_q      <= 8'd0;
      first_q    <= 1'b0;
      err_len_q  <= 1'b0;
      err_csum_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      rem_q      <= rem_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      err_len_q  <= err_len_d;
      err_csum_q <= err_csum_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Entry layout: {sof, eof, data}.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {first_q, (rem_q == 8'd1), IN_DATA};
  end

  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign OUT_VALID = !RST && !empty;
  assign pop       = OUT_VALID && OUT_READY;
  assign OUT_DATA  = OUT_VALID ? head[7:0] : 8'd0;
  assign OUT_SOF   = OUT_VALID && head[9];
  assign OUT_EOF   = OUT_VALID && head[8];
  assign ERR_LEN   = err_len_q;
  assign ERR_CSUM  = err_csum_q;
  assign FRAME_CNT = cnt_q;

endmodule
